// File: rtl/uart_tx_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_rx
// Purpose  : Full-duplex 8N1 UART. The transmitter serialises a parallel word
//            on a start request, and the receiver deserialises the rx line and
//            pulses a valid strobe for each good frame. Both halves share one
//            clock and are otherwise fully independent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1       clock
//   arstn          in   1       synchronous active-low reset
//   tx_ready       in   1       TX start request (level-sampled while idle)
//   tx_data        in   W_DATA  word to send, captured at accept
//   tx_busy        out  1       TX frame in progress
//   tx             out  1       serial out, idle high
//   rx             in   1       serial in, asynchronous to clk
//   rx_data_valid  out  1       one-cycle pulse: rx_data holds a new word
//   rx_data        out  W_DATA  last received word
// ============================================================================
module uart_tx_rx #(
    parameter int CLK_FREQUENCY = 40_000_000,
    parameter int BITRATE       = 115200,
    parameter int W_PACKAGE     = 10,
    parameter int W_DATA        = 8
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              tx_ready,
    input  logic [W_DATA-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx,
    input  logic              rx,
    output logic              rx_data_valid,
    output logic [W_DATA-1:0] rx_data
);

    localparam int BIT_PERIOD = CLK_FREQUENCY / BITRATE;
    localparam int W_CNT      = $clog2(BIT_PERIOD + 1);
    localparam int W_IDX      = $clog2(W_DATA + 1);
    // Payload bits in a frame: everything except the start and stop bits.
    localparam int c_N_DATA   = W_PACKAGE - 2;

    localparam logic [W_CNT-1:0] c_BIT_LAST = W_CNT'(BIT_PERIOD - 1);
    localparam logic [W_CNT-1:0] c_HALF_BIT = W_CNT'(BIT_PERIOD / 2);
    localparam logic [W_CNT-1:0] c_CNT_ONE  = W_CNT'(1);
    localparam logic [W_IDX-1:0] c_IDX_LAST = W_IDX'(c_N_DATA - 1);
    localparam logic [W_IDX-1:0] c_IDX_ONE  = W_IDX'(1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t         tx_state_q, tx_state_d;
    logic [W_CNT-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [W_IDX-1:0]  tx_idx_q,   tx_idx_d;
    logic [W_DATA-1:0] tx_shift_q, tx_shift_d;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // tx is decoded straight from the state register, so the line reflects
    // the new state one cycle after the accept edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_busy    = (tx_state_q != TX_IDLE);
        tx         = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_ready) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_shift_d = tx_data;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (tx_cnt_q == c_BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_CNT_ONE;
                end
            end
            TX_DATA: begin
                tx = tx_shift_q[0];
                if (tx_cnt_q == c_BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = tx_idx_q + c_IDX_ONE;
                    if (tx_idx_q == c_IDX_LAST) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + c_CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == c_BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    // RX_BREAK parks the receiver after a framing error until the line is
    // released, so a held-low line is not mistaken for a new start bit.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    logic [W_CNT-1:0]  rx_cnt_q,   rx_cnt_d;
    logic [W_IDX-1:0]  rx_idx_q,   rx_idx_d;
    logic [W_DATA-1:0] rx_shift_q, rx_shift_d;
    logic [W_DATA-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              w_rx_fall;
    logic              w_rx_tick;

    // Synchroniser and edge-history flops reset to the idle-high line level
    // so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign w_rx_fall = rx_prev_q & ~rx_sync_q;
    // Down-counter: a half bit from the start edge, then a full bit between
    // samples, puts every sample near the middle of its bit.
    assign w_rx_tick = (rx_cnt_q == '0);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = c_HALF_BIT;
                end
            end
            RX_START: begin
                if (w_rx_tick) begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = c_BIT_LAST;
                        rx_idx_d   = '0;
                    end else begin
                        // Line already back high: a glitch, not a start bit.
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[W_DATA-1:1]};
                    rx_cnt_d   = c_BIT_LAST;
                    rx_idx_d   = rx_idx_q + c_IDX_ONE;
                    if (rx_idx_q == c_IDX_LAST) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    if (rx_sync_q) begin
                        // Returning to idle at mid stop bit lets the next
                        // start edge be caught for back-to-back frames.
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_data_valid = rx_valid_q;
    assign rx_data       = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_rx
// Purpose  : Self-checking bench for uart_tx_rx. TX frames are looped back
//            into RX and compared against an idealised 8N1 frame model; RX
//            corner cases are driven by bit-banging the rx line directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int BP     = CLK_HZ / BAUD;          // 16 cycles per bit
    // Expected valid latency from the start edge: 2 + 9.5 bit periods.
    localparam int LAT_NOM = 2 + (19 * BP) / 2;
    localparam int LAT_LO  = LAT_NOM - BP / 2;
    localparam int LAT_HI  = LAT_NOM + BP / 2;

    logic       clk = 1'b0;
    logic       arstn;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx;
    logic       rx_line;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       loop_en;
    logic       rx_drv;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_tx_rx #(
        .CLK_FREQUENCY (CLK_HZ),
        .BITRATE       (BAUD),
        .W_PACKAGE     (10),
        .W_DATA        (8)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .tx            (tx),
        .rx            (rx_line),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         dbl_cnt = 0;
    int         last_valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Receive monitor: every valid pulse is counted and its word queued.
    always @(negedge clk) begin
        if (rx_data_valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            rx_q.push_back(rx_data);
            if (prev_valid === 1'b1) dbl_cnt <= dbl_cnt + 1;
        end
        prev_valid <= rx_data_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rx_word(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: actual=<no word> required=0x%0h", name, exp);
        end else begin
            chk(name, 32'(rx_q.pop_front()), 32'(exp));
        end
    endtask

    // One looped-back TX frame: checks accept timing, every bit at mid-bit
    // against the ideal frame, busy duration, the return to idle, and the
    // matching RX pulse, word and latency.
    task automatic tx_frame(input logic [7:0] d, input int hold, input logic [7:0] post,
                            input logic [7:0] exp_rx, input bit chained, input bit keep_ready);
        logic [9:0] fb;
        int vc0, c0, busy_err, lat;
        fb  = {1'b1, d, 1'b0};
        vc0 = valid_cnt;
        if (!chained) begin
            @(negedge clk);
            tx_data  = d;
            tx_ready = 1'b1;
        end
        @(negedge clk);
        c0 = cyc;
        chk("tx_accept", 32'({tx_busy, tx}), 32'h2);
        tx_data  = post;
        busy_err = 0;
        for (int k = 0; k < 10 * BP; k++) begin
            if (k > 0) @(negedge clk);
            if (k == hold - 1 && !keep_ready) tx_ready = 1'b0;
            if (tx_busy !== 1'b1) busy_err++;
            if (k % BP == BP / 2) chk("tx_bit", 32'(tx), 32'(fb[k / BP]));
        end
        @(negedge clk);
        chk("tx_busy_len", busy_err, 0);
        chk("tx_end_idle", 32'({tx_busy, tx}), 32'h1);
        chk("rx_pulses", valid_cnt - vc0, 1);
        chk_rx_word("rx_data", exp_rx);
        lat = last_valid_cyc - c0;
        chk("rx_latency_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 1);
    endtask

    task automatic gap_idle(input int n);
        int err;
        err = 0;
        repeat (n) begin
            @(negedge clk);
            if ({tx_busy, tx} !== 2'b01) err++;
        end
        chk("gap_idle", err, 0);
    endtask

    // Bit-bang one frame onto rx, then leave the line high for two bits.
    task automatic rx_send(input logic [7:0] d, input logic stop);
        logic [9:0] fb;
        fb = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = fb[i];
            repeat (BP - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BP) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic [7:0] post;
        logic [7:0] exp_rx;
        int         gap;
    } vec_t;

    vec_t tv[7];

    initial begin
        int         vc0;
        logic [7:0] d, post;
        int         hold;

        tv[0] = '{8'h6B, 2,      8'h6B, 8'h6B, 10};
        tv[1] = '{8'h6B, 1,      8'h94, 8'h6B, 3};
        tv[2] = '{8'h94, 1,      8'h94, 8'h94, 25};
        tv[3] = '{8'h00, 3,      8'h00, 8'h00, 1};
        tv[4] = '{8'hFF, 3 * BP, 8'hFF, 8'hFF, 40};
        tv[5] = '{8'h55, 1,      8'hAA, 8'h55, 7};
        tv[6] = '{8'hA5, BP,     8'h5A, 8'hA5, 12};

        arstn    = 1'b0;
        tx_ready = 1'b0;
        tx_data  = 8'h00;
        loop_en  = 1'b1;
        rx_drv   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(tx_busy), 0);
        chk("reset_valid", 32'(rx_data_valid), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        arstn = 1'b1;
        repeat (5) @(negedge clk);

        // Directed vectors, including a tx_data change right after accept.
        for (int i = 0; i < 7; i++) begin
            tx_frame(tv[i].data, tv[i].hold, tv[i].post, tv[i].exp_rx, 1'b0, 1'b0);
            gap_idle(tv[i].gap);
        end

        // Back-to-back: tx_ready held across the frame end starts a new one.
        tx_frame(8'h3C, 0, 8'hC3, 8'h3C, 1'b0, 1'b1);
        tx_frame(8'hC3, 1, 8'hC3, 8'hC3, 1'b1, 1'b0);
        gap_idle(5);

        // Randomised frames with random hold lengths and random gaps.
        for (int r = 0; r < 10; r++) begin
            d    = 8'($urandom);
            post = 8'($urandom);
            hold = int'($urandom_range(1, 3 * BP));
            tx_frame(d, hold, post, d, 1'b0, 1'b0);
            gap_idle(int'($urandom_range(1, 40)));
        end

        // Short low glitch on rx: no pulse, word kept, receiver still usable.
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (4) @(negedge clk);
        vc0    = valid_cnt;
        d      = rx_data;
        rx_drv = 1'b0;
        repeat (BP / 2 - 3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BP) @(negedge clk);
        chk("glitch_no_pulse", valid_cnt - vc0, 0);
        chk("glitch_rx_data_kept", 32'(rx_data), 32'(d));
        rx_send(8'h5A, 1'b1);
        chk("after_glitch_pulse", valid_cnt - vc0, 1);
        chk_rx_word("after_glitch_data", 8'h5A);

        // Framing error: stop bit 0 gives no pulse and leaves rx_data alone.
        vc0 = valid_cnt;
        rx_send(8'h3C, 1'b0);
        chk("frame_err_no_pulse", valid_cnt - vc0, 0);
        chk("frame_err_rx_data", 32'(rx_data), 32'h5A);
        rx_send(8'hC3, 1'b1);
        chk("after_frame_err_pulse", valid_cnt - vc0, 1);
        chk_rx_word("after_frame_err_data", 8'hC3);

        // Reset in the middle of a looped-back frame.
        loop_en = 1'b1;
        @(negedge clk);
        tx_data  = 8'hE7;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        repeat (4 * BP) @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        chk("midreset_tx", 32'(tx), 1);
        chk("midreset_busy", 32'(tx_busy), 0);
        chk("midreset_valid", 32'(rx_data_valid), 0);
        chk("midreset_rx_data", 32'(rx_data), 0);
        arstn = 1'b1;
        vc0   = valid_cnt;
        gap_idle(12 * BP);
        chk("midreset_no_pulse", valid_cnt - vc0, 0);

        chk("valid_single_cycle", dbl_cnt, 0);
        chk("rx_words_all_checked", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
